// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, FSM state encoding, datapath select codes.
// MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state to the encoding.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;
`endif

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] ALU_OP_ADD  = 2'd0;
  localparam logic [1:0] ALU_OP_CMP  = 2'd1;
  localparam logic [1:0] ALU_OP_FUNC = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // Instruction class, one-hot; all-zero means unsupported opcode
  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic op;
    logic opimm;
    logic lui;
    logic auipc;
  } cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode to instruction-class one-hot decoder for the multi-cycle sequencer.
module mc_ctrl_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls_c
);

  // Pure opcode match; unknown opcodes leave every class bit clear
  always_comb begin
    cls_c = '0;
    case (opcode)
      OPC_LOAD:   cls_c.load   = 1'b1;
      OPC_STORE:  cls_c.store  = 1'b1;
      OPC_BRANCH: cls_c.branch = 1'b1;
      OPC_JAL:    cls_c.jal    = 1'b1;
      OPC_JALR:   cls_c.jalr   = 1'b1;
      OPC_OP:     cls_c.op     = 1'b1;
      OPC_OPIMM:  cls_c.opimm  = 1'b1;
      OPC_LUI:    cls_c.lui    = 1'b1;
      OPC_AUIPC:  cls_c.auipc  = 1'b1;
      default:    cls_c        = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH, DECODE, EXEC, MEM, WB plus retire counter.
// Define MC_CTRL_ILLEGAL_TRAP_EN to park in TRAP on an unsupported opcode instead of
// skipping it as a NOP.
module mc_ctrl_fsm
  import rv_pkg::*;
#(
  parameter int unsigned RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [RET_W-1:0] retired,
  output logic             illegal
);

  state_t state;
  cls_t   cls_c;
  logic   legal_c;
  logic   unused_instr_bits;

  assign unused_instr_bits = ^instr[31:7];
  assign legal_c           = |cls_c;

  mc_ctrl_decode u_decode (
    .opcode (instr[6:0]),
    .cls_c  (cls_c)
  );

  // State, retire counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) state <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cls_c.load || cls_c.store) begin
            state <= ST_MEM;
          end else if (cls_c.branch) begin
            state   <= ST_FETCH;
            retired <= retired + RET_W'(1);
          end else if (legal_c) begin
            state <= ST_WB;
          end else begin
            illegal <= 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state   <= ST_TRAP;
`else
            state   <= ST_FETCH;
`endif
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (cls_c.store) begin
              state   <= ST_FETCH;
              retired <= retired + RET_W'(1);
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          retired <= retired + RET_W'(1);
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ST_TRAP: begin
          state <= ST_TRAP;
        end
`endif
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Per-state datapath controls decoded from the registered state and the IR
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = ALU_B_RS2;
    alu_op    = ALU_OP_ADD;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
        pc_sel   = PC_SEL_PC4;
      end
      ST_EXEC: begin
        if (cls_c.op) begin
          alu_op = ALU_OP_FUNC;
        end else if (cls_c.opimm) begin
          alu_b_sel = ALU_B_IMM;
          alu_op    = ALU_OP_FUNC;
        end else if (cls_c.load || cls_c.store) begin
          alu_b_sel = ALU_B_IMM;
        end else if (cls_c.branch) begin
          alu_op = ALU_OP_CMP;
          pc_we  = br_taken;
          pc_sel = PC_SEL_BR;
        end else if (cls_c.jal) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_BR;
        end else if (cls_c.jalr) begin
          alu_b_sel = ALU_B_IMM;
          pc_we     = 1'b1;
          pc_sel    = PC_SEL_JALR;
        end else if (cls_c.lui) begin
          alu_a_sel = ALU_A_ZERO;
          alu_b_sel = ALU_B_IMM;
        end else if (cls_c.auipc) begin
          alu_a_sel = ALU_A_PC;
          alu_b_sel = ALU_B_IMM;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls_c.store;
      end
      ST_WB: begin
        rf_we = 1'b1;
        if (cls_c.load)                   wb_sel = WB_SEL_MEM;
        else if (cls_c.jal || cls_c.jalr) wb_sel = WB_SEL_PC4;
        else                              wb_sel = WB_SEL_ALU;
      end
      default: begin
      end
    endcase
  end

endmodule
